ram_scan_unit: RTL and testbench

RAM_SCAN_UNIT -- requirements
Module: ram_scan_unit

---
 rtl/ram_scan_unit_if.sv | 31 +++
 rtl/ram_scan_unit.sv | 135 +++++++++++++
 tb/tb_ram_scan_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_scan_unit_if.sv
// Bus bundle for ram_scan_unit: write port, manual read port,
// scan/clear controls and registered read results.
interface ram_scan_unit_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              scan_en;
  logic              clear;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] cur_addr;
  logic              scan_tick;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr, scan_en, clear,
    input  rd_data, cur_addr,
    input  scan_tick, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr, scan_en, clear,
    output rd_data, cur_addr,
    output scan_tick, busy
  );
endinterface

// File: rtl/ram_scan_unit.sv
// Read-first RAM with manual read and timed address scan.
// Define RAM_SCAN_CLEAR_EN to build the sequential CLEAR mode.
module ram_scan_unit #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 50000000
) (
  input logic            clock,
  input logic            reset,
  ram_scan_unit_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1
`ifdef RAM_SCAN_CLEAR_EN
    , CLEAR = 2'd2
`endif
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] cur_q;
  logic              tick_q;

  logic              clr_req;
  logic              in_clear;
  logic              div_last;
  logic              scan_enter;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] rd_sel;

`ifdef RAM_SCAN_CLEAR_EN
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_last;

  assign clr_req  = bus.clear && (state != CLEAR);
  assign in_clear = (state == CLEAR);
  assign clr_last = (clr_idx == ADDR_W'(DEPTH-1));
`else
  assign clr_req  = 1'b0;
  assign in_clear = 1'b0;
`endif

  assign div_last   = (div == DIV_W'(SCAN_DIV-1));
  assign scan_enter = (state_nx == SCAN) && (state != SCAN);
  assign rd_sel     = (state == SCAN) ? cnt : bus.rd_addr;

  always_ff @(posedge clock) begin
    if (reset) state <= MANUAL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MANUAL: if (bus.scan_en) state_nx = SCAN;
      SCAN:   if (!bus.scan_en) state_nx = MANUAL;
`ifdef RAM_SCAN_CLEAR_EN
      CLEAR:  if (clr_last)
                state_nx = bus.scan_en ? SCAN : MANUAL;
`endif
      default: state_nx = MANUAL;
    endcase
`ifdef RAM_SCAN_CLEAR_EN
    if (clr_req) state_nx = CLEAR;
`endif
  end

  // A clear request steals the write port for its entry cycle.
  always_comb begin
    we = bus.wr_en && !clr_req && !in_clear;
    wa = bus.wr_addr;
    wd = bus.wr_data;
`ifdef RAM_SCAN_CLEAR_EN
    if (in_clear) begin
      we = 1'b1;
      wa = clr_idx;
      wd = '0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset && we) mem[wa] <= wd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q   <= '0;
      cur_q  <= '0;
      tick_q <= 1'b0;
      div    <= '0;
      cnt    <= '0;
    end else begin
      tick_q <= 1'b0;
      if (!in_clear) begin
        rd_q  <= mem[rd_sel];
        cur_q <= rd_sel;
      end
      if (scan_enter) begin
        div <= '0;
        cnt <= '0;
      end else if (state == SCAN && state_nx == SCAN) begin
        if (div_last) begin
          div    <= '0;
          cnt    <= cnt + 1'b1;
          tick_q <= 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

`ifdef RAM_SCAN_CLEAR_EN
  always_ff @(posedge clock) begin
    if (reset || !in_clear) clr_idx <= '0;
    else                    clr_idx <= clr_idx + 1'b1;
  end
`endif

  assign bus.rd_data   = rd_q;
  assign bus.cur_addr  = cur_q;
  assign bus.scan_tick = tick_q;
  assign bus.busy      = in_clear;
endmodule

// File: tb/tb_ram_scan_unit.sv
// Directed bench for ram_scan_unit with a cycle model of the
// read/scan/clear rules and hand-computed spot checks.
module tb_ram_scan_unit;
  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DIV   = 4;
  localparam int DEPTH = 32;
`ifdef RAM_SCAN_CLEAR_EN
  localparam bit CLEN = 1'b1;
`else
  localparam bit CLEN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram_scan_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  ram_scan_unit #(
    .DATA_W(DW), .ADDR_W(AW), .SCAN_DIV(DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: mode 0 manual, 1 scan, 2 clear.
  int m_mode, m_div, m_cnt, m_clr;
  int m_mem [DEPTH];
  bit m_val [DEPTH];
  int e_rd, e_cur;
  bit e_tick, e_busy, e_rd_ok;
  bit started = 1'b0;

  always @(posedge clock) begin : model
    int sel;
    bit creq;
    if (reset) begin
      m_mode = 0; m_div = 0; m_cnt = 0; m_clr = 0;
      e_rd = 0; e_cur = 0; e_tick = 0; e_rd_ok = 1;
      started = 1'b1;
    end else begin
      creq = CLEN && bus.clear && m_mode != 2;
      if (m_mode != 2) begin
        sel = (m_mode == 1) ? m_cnt : int'(bus.rd_addr);
        e_rd = m_mem[sel];
        e_rd_ok = m_val[sel];
        e_cur = sel;
      end
      e_tick = 0;
      if (m_mode == 2) begin
        m_mem[m_clr] = 0;
        m_val[m_clr] = 1;
      end else if (!creq && bus.wr_en) begin
        m_mem[bus.wr_addr] = int'(bus.wr_data);
        m_val[bus.wr_addr] = 1;
      end
      if (creq) begin
        m_mode = 2;
        m_clr = 0;
      end else begin
        case (m_mode)
          0: if (bus.scan_en) begin
               m_mode = 1; m_div = 0; m_cnt = 0;
             end
          1: if (!bus.scan_en) m_mode = 0;
             else if (m_div == DIV-1) begin
               m_div = 0;
               m_cnt = (m_cnt + 1) % DEPTH;
               e_tick = 1;
             end else m_div++;
          default:
             if (m_clr == DEPTH-1) begin
               m_mode = bus.scan_en ? 1 : 0;
               m_div = 0; m_cnt = 0;
             end else m_clr++;
        endcase
      end
    end
    e_busy = (m_mode == 2);
  end

  always @(negedge clock) begin
    if (started) begin
      check("cur_addr", 32'(bus.cur_addr), 32'(e_cur));
      check("scan_tick", 32'(bus.scan_tick), 32'(e_tick));
      check("busy", 32'(bus.busy), 32'(e_busy));
      if (e_rd_ok)
        check("rd_data", 32'(bus.rd_data), 32'(e_rd));
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[AW-1:0];
    bus.wr_data = d[DW-1:0];
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic fill();
    for (int n = 0; n < DEPTH; n++) wr(n, n % 16);
  endtask

  initial begin
    int ticks;
    int n;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rd_addr = 0; bus.scan_en = 0; bus.clear = 0;
    step();
    step();
    check("rst_rd", 32'(bus.rd_data), 0);
    check("rst_cur", 32'(bus.cur_addr), 0);
    check("rst_tick", 32'(bus.scan_tick), 0);
    check("rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;

    wr(3, 'hA);
    bus.rd_addr = 3;
    step();
    check("rd_a3", 32'(bus.rd_data), 'hA);
    check("cur_a3", 32'(bus.cur_addr), 3);
    check("model_a3", 32'(e_rd), 'hA);

    wr(5, 'h2);
    bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 'h7;
    bus.rd_addr = 5;
    step();
    bus.wr_en = 0;
    check("rdfirst_old", 32'(bus.rd_data), 'h2);
    step();
    check("rdfirst_new", 32'(bus.rd_data), 'h7);

    fill();
    bus.scan_en = 1;
    step();
    step();
    check("scan_first", 32'(bus.cur_addr), 0);
    ticks = 0;
    for (int i = 0; i < 127; i++) begin
      step();
      ticks += int'(bus.scan_tick);
    end
    check("scan_ticks", 32'(ticks), 32);
    check("scan_last", 32'(bus.cur_addr), 31);
    check("scan_last_rd", 32'(bus.rd_data), 'hF);
    step();
    check("scan_wrap", 32'(bus.cur_addr), 0);
    repeat (36) step();
    check("scan_at9", 32'(bus.cur_addr), 9);
    check("scan_at9_rd", 32'(bus.rd_data), 9);
    bus.scan_en = 0;
    bus.rd_addr = 20;
    step();
    step();
    check("man_cur", 32'(bus.cur_addr), 20);
    check("man_rd", 32'(bus.rd_data), 4);
    ticks = 0;
    repeat (8) begin
      step();
      ticks += int'(bus.scan_tick);
    end
    check("man_noticks", 32'(ticks), 0);

`ifdef RAM_SCAN_CLEAR_EN
    bus.clear = 1; bus.wr_en = 1;
    bus.wr_addr = 7; bus.wr_data = 'hE;
    step();
    bus.clear = 0;
    bus.wr_addr = 31; bus.wr_data = 'h5;
    n = 0;
    while (n < 40 && bus.busy) begin
      n++;
      bus.clear = (n == 5);
      step();
    end
    bus.clear = 0; bus.wr_en = 0;
    check("busy_cycles", 32'(n), 32);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr = i[AW-1:0];
      step();
      check("clr_zero", 32'(bus.rd_data), 0);
    end

    fill();
    bus.clear = 1;
    step();
    bus.clear = 0;
    repeat (10) step();
    reset = 1;
    step();
    reset = 0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_rd", 32'(bus.rd_data), 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr = i[AW-1:0];
      step();
      check("abort_mem", 32'(bus.rd_data),
            (i < 10) ? 0 : 32'(i % 16));
    end
`else
    bus.clear = 1; bus.wr_en = 1;
    bus.wr_addr = 4; bus.wr_data = 'hC;
    step();
    check("noclr_busy", 32'(bus.busy), 0);
    bus.clear = 0; bus.wr_en = 0;
    bus.rd_addr = 4;
    step();
    check("noclr_wr", 32'(bus.rd_data), 'hC);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
